// File: rtl/f_fetch_unit.sv
// Fetch stage plus F/D pipeline register: owns the PC, resolves D-stage
// control transfers (one delay slot, no squash) and latches the fetched word.
module f_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] F_instr,
  input  logic [2:0]  D_npc_op,
  input  logic        D_equal,
  input  logic [31:0] D_rs_data,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc8,
  output logic        D_redirect
);

  typedef enum logic [2:0] {
    NPC_SEQ = 3'd0,
    NPC_BEQ = 3'd1,
    NPC_BNE = 3'd2,
    NPC_J   = 3'd3,
    NPC_JR  = 3'd4
  } npcOp_e;

  logic [31:0] fPc_q, fPc_d;
  logic [31:0] dPc_q, dPc_d;
  logic [31:0] dInstr_q, dInstr_d;

  logic [31:0] dPcPlus4;
  logic [31:0] brOffset;
  logic [31:0] brTarget;
  logic [31:0] jTarget;
  logic [31:0] nextPc;
  logic        redirect;

  assign dPcPlus4 = dPc_q + 32'd4;
  assign brOffset = {{14{dInstr_q[15]}}, dInstr_q[15:0], 2'b00};
  assign brTarget = dPcPlus4 + brOffset;
  assign jTarget  = {dPcPlus4[31:28], dInstr_q[25:0], 2'b00};

  // Undefined op codes 5-7 fall into the default arm and fetch sequentially.
  always_comb begin
    redirect = 1'b0;
    nextPc   = fPc_q + 32'd4;
    case (npcOp_e'(D_npc_op))
      NPC_BEQ: begin
        redirect = D_equal;
        if (D_equal) nextPc = brTarget;
      end
      NPC_BNE: begin
        redirect = !D_equal;
        if (!D_equal) nextPc = brTarget;
      end
      NPC_J: begin
        redirect = 1'b1;
        nextPc   = jTarget;
      end
      NPC_JR: begin
        redirect = 1'b1;
        nextPc   = D_rs_data;
      end
      default: begin
        redirect = 1'b0;
      end
    endcase
  end

  // A stalled transfer stays in D and is re-resolved when the stall lifts.
  always_comb begin
    fPc_d    = fPc_q;
    dPc_d    = dPc_q;
    dInstr_d = dInstr_q;
    if (!stall) begin
      fPc_d    = nextPc;
      dPc_d    = fPc_q;
      dInstr_d = F_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fPc_q    <= PC_RESET;
      dPc_q    <= PC_RESET;
      dInstr_q <= 32'd0;
    end else begin
      fPc_q    <= fPc_d;
      dPc_q    <= dPc_d;
      dInstr_q <= dInstr_d;
    end
  end

  assign F_pc       = fPc_q;
  assign D_pc       = dPc_q;
  assign D_instr    = dInstr_q;
  assign D_pc8      = dPc_q + 32'd8;
  assign D_redirect = redirect;

endmodule
